// File: rtl/gray_to_rgb_mapper.sv
// Grayscale/edge-magnitude to RGB expander with selectable colour mode, a two-stage stall-all
// valid/ready pipeline, frame-end tagging and a per-frame output pixel counter.
module gray_to_rgb_mapper #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  grayscale_i,
  input  logic             done_i,
  input  logic             last_i,
  input  logic [1:0]       mode_i,
  input  logic [IN_W-1:0]  thresh_i,
  output logic             ready_o,
  output logic [OUT_W-1:0] red_o,
  output logic [OUT_W-1:0] green_o,
  output logic [OUT_W-1:0] blue_o,
  output logic             done_o,
  output logic             last_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [1:0] {
    ModeReplicate = 2'd0,
    ModeThreshold = 2'd1,
    ModeInvert    = 2'd2,
    ModeHeat      = 2'd3
  } mode_e;

  localparam logic [OUT_W-1:0] MaxVal = '1;

  logic             adv;
  logic             accept;
  logic [OUT_W-1:0] scaled;

  logic             s1_valid_q;
  logic [OUT_W-1:0] s1_s_q;
  logic             s1_t_q;
  mode_e            s1_mode_q;
  logic             s1_last_q;

  logic [OUT_W-1:0] red_q, green_q, blue_q;
  logic [OUT_W-1:0] red_d, green_d, blue_d;
  logic             done_q;
  logic             last_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] heat_f;

  assign adv     = ready_i | ~done_q;
  assign ready_o = adv & ~rst;
  assign accept  = done_i & ready_o;

  // MSB replication into the extra low bits so full scale stays full scale.
  if (OUT_W == IN_W) begin : g_scale_eq
    assign scaled = grayscale_i;
  end else begin : g_scale_ext
    assign scaled = {grayscale_i, grayscale_i[IN_W-1 -: (OUT_W-IN_W)]};
  end

  assign heat_f = {s1_s_q[OUT_W-2:0], 1'b0};

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    unique case (s1_mode_q)
      ModeReplicate: begin
        red_d   = s1_s_q;
        green_d = s1_s_q;
        blue_d  = s1_s_q;
      end
      ModeThreshold: begin
        red_d   = s1_t_q ? MaxVal : '0;
        green_d = s1_t_q ? MaxVal : '0;
        blue_d  = s1_t_q ? MaxVal : '0;
      end
      ModeInvert: begin
        red_d   = MaxVal - s1_s_q;
        green_d = MaxVal - s1_s_q;
        blue_d  = MaxVal - s1_s_q;
      end
      ModeHeat: begin
        // Lower half ramps green up / blue down, upper half ramps red up / green down.
        if (!s1_s_q[OUT_W-1]) begin
          green_d = heat_f;
          blue_d  = MaxVal - heat_f;
        end else begin
          red_d   = heat_f;
          green_d = MaxVal - heat_f;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (done_q && ready_i) begin
      count_d = last_q ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= '0;
      s1_t_q     <= 1'b0;
      s1_mode_q  <= ModeReplicate;
      s1_last_q  <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      if (adv) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_s_q    <= scaled;
          s1_t_q    <= (grayscale_i >= thresh_i);
          s1_mode_q <= mode_e'(mode_i);
          s1_last_q <= last_i;
        end
        done_q <= s1_valid_q;
        last_q <= s1_valid_q & s1_last_q;
        if (s1_valid_q) begin
          red_q   <= red_d;
          green_q <= green_d;
          blue_q  <= blue_d;
        end
      end
      count_q <= count_d;
    end
  end

  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;
  assign done_o  = done_q;
  assign last_o  = last_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_gray_to_rgb_mapper.sv
// Directed bench for gray_to_rgb_mapper: an 8/8 instance and an 8/10 instance share stimulus.
module tb_gray_to_rgb_mapper;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gray;
  logic       done_in;
  logic       last_in;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic       ready_in;

  logic        rdy8, dn8, ls8;
  logic [7:0]  r8, g8, b8;
  logic [21:0] cnt8;
  logic        rdy10, dn10, ls10;
  logic [9:0]  r10, g10, b10;
  logic [21:0] cnt10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gray_to_rgb_mapper #(.IN_W(8), .OUT_W(8), .CNT_W(22)) dut8 (
    .clk(clk), .rst(rst), .grayscale_i(gray), .done_i(done_in), .last_i(last_in),
    .mode_i(mode), .thresh_i(thresh), .ready_o(rdy8), .red_o(r8), .green_o(g8), .blue_o(b8),
    .done_o(dn8), .last_o(ls8), .ready_i(ready_in), .count_o(cnt8)
  );

  gray_to_rgb_mapper #(.IN_W(8), .OUT_W(10), .CNT_W(22)) dut10 (
    .clk(clk), .rst(rst), .grayscale_i(gray), .done_i(done_in), .last_i(last_in),
    .mode_i(mode), .thresh_i(thresh), .ready_o(rdy10), .red_o(r10), .green_o(g10), .blue_o(b10),
    .done_o(dn10), .last_o(ls10), .ready_i(ready_in), .count_o(cnt10)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  g;
    logic [7:0]  th;
    logic [23:0] exp8;
    logic [29:0] exp10;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    done_in = 1'b0;
    step();
    chk("reset_out8", {dn8, ls8, cnt8, r8, g8, b8, rdy8}, 64'd0);
    chk("reset_out10", {dn10, ls10, cnt10, r10, g10, b10, rdy10}, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    int sent;
    int got;
    int cnt_m;
    logic [23:0] held;
    logic was_stall;

    vecs[0]  = '{2'd0, 8'h80, 8'd0,   {8'd128, 8'd128, 8'd128}, {10'h202, 10'h202, 10'h202}};
    vecs[1]  = '{2'd0, 8'hFF, 8'd0,   {8'd255, 8'd255, 8'd255}, {10'h3FF, 10'h3FF, 10'h3FF}};
    vecs[2]  = '{2'd0, 8'h00, 8'd0,   {8'd0,   8'd0,   8'd0},   {10'd0,   10'd0,   10'd0}};
    vecs[3]  = '{2'd1, 8'd99, 8'd100, {8'd0,   8'd0,   8'd0},   {10'd0,   10'd0,   10'd0}};
    vecs[4]  = '{2'd1, 8'd100, 8'd100, {8'd255, 8'd255, 8'd255}, {10'd1023, 10'd1023, 10'd1023}};
    vecs[5]  = '{2'd2, 8'd55, 8'd0,   {8'd200, 8'd200, 8'd200}, {10'd803, 10'd803, 10'd803}};
    vecs[6]  = '{2'd3, 8'd64, 8'd0,   {8'd0,   8'd128, 8'd127}, {10'd0,   10'd514, 10'd509}};
    vecs[7]  = '{2'd3, 8'd200, 8'd0,  {8'd144, 8'd111, 8'd0},   {10'd582, 10'd441, 10'd0}};
    vecs[8]  = '{2'd3, 8'd255, 8'd0,  {8'd254, 8'd1,   8'd0},   {10'd1022, 10'd1,  10'd0}};
    vecs[9]  = '{2'd1, 8'd255, 8'd255, {8'd255, 8'd255, 8'd255}, {10'd1023, 10'd1023, 10'd1023}};
    vecs[10] = '{2'd1, 8'd0,  8'd1,   {8'd0,   8'd0,   8'd0},   {10'd0,   10'd0,   10'd0}};
    vecs[11] = '{2'd3, 8'd0,  8'd0,   {8'd0,   8'd0,   8'd255}, {10'd0,   10'd0,   10'd1023}};
    vecs[12] = '{2'd3, 8'd128, 8'd0,  {8'd0,   8'd255, 8'd0},   {10'd4,   10'd1019, 10'd0}};

    gray = '0; done_in = 1'b0; last_in = 1'b0; mode = 2'd0; thresh = '0; ready_in = 1'b1;
    rst = 1'b1;
    do_reset();

    // Replicate stream 1..9 back-to-back; outputs trail acceptance by two edges.
    for (int c = 0; c <= 10; c++) begin
      done_in = (c < 9);
      gray    = 8'(c + 1);
      step();
      if (c == 0) chk("rep_latency", dn8, 1'b0);
      else if (c <= 9) chk("rep_pix", {dn8, r8, g8, b8}, {1'b1, 8'(c), 8'(c), 8'(c)});
      else begin
        chk("rep_idle", dn8, 1'b0);
        chk("rep_count", cnt8, 22'd9);
      end
    end

    for (int i = 0; i < 13; i++) begin
      mode = vecs[i].mode; gray = vecs[i].g; thresh = vecs[i].th; done_in = 1'b1;
      step();
      done_in = 1'b0;
      step();
      chk($sformatf("vec%0d_8", i), {dn8, r8, g8, b8}, {1'b1, vecs[i].exp8});
      chk($sformatf("vec%0d_10", i), {dn10, r10, g10, b10}, {1'b1, vecs[i].exp10});
    end

    // Mode switch mid-stream: in-flight pixels keep their sampled mode.
    do_reset();
    mode = 2'd1; thresh = 8'd100; gray = 8'd99; done_in = 1'b1;
    step();
    gray = 8'd100;
    step();
    chk("modesw_p0", {dn8, r8}, {1'b1, 8'd0});
    mode = 2'd2; gray = 8'd55; thresh = 8'd0;
    step();
    chk("modesw_p1", {dn8, r8, g8, b8}, {1'b1, 8'd255, 8'd255, 8'd255});
    done_in = 1'b0;
    step();
    chk("modesw_p2", {dn8, r8, g8, b8}, {1'b1, 8'd200, 8'd200, 8'd200});

    // Backpressure: ready_i low for 4 cycles, pixel 5 tagged last.
    do_reset();
    mode = 2'd0; sent = 0; got = 0; cnt_m = 0; held = '0; was_stall = 1'b0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      done_in  = (sent < 8);
      gray     = 8'(sent + 1);
      last_in  = (sent == 4);
      ready_in = !(c >= 4 && c < 8);
      @(negedge clk);
      if (was_stall) chk("bp_hold", {r8, g8, b8, dn8}, {held, 1'b1});
      if (dn8 && !ready_in) begin
        chk("bp_ready_o", rdy8, 1'b0);
        held = {r8, g8, b8};
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (dn8 && ready_in) begin
        chk("bp_pix", {r8, ls8}, {8'(got + 1), (got == 4)});
        chk("bp_cnt", cnt8, 22'(cnt_m));
        cnt_m = (got == 4) ? 0 : cnt_m + 1;
        got++;
      end
      if (done_in && rdy8) sent++;
      @(posedge clk);
      #1;
    end
    chk("bp_all_out", got, 8);
    done_in = 1'b0; last_in = 1'b0; ready_in = 1'b1;
    step();
    chk("bp_final_cnt", {dn8, cnt8}, {1'b0, 22'd3});

    // Reset with two pixels in flight: nothing emerges, counter clears.
    gray = 8'd10; done_in = 1'b1;
    step();
    gray = 8'd11;
    step();
    done_in = 1'b0;
    chk("rstmid_inflight", {dn8, r8}, {1'b1, 8'd10});
    rst = 1'b1;
    step();
    chk("rstmid_out", {dn8, ls8, cnt8, r8, rdy8}, 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rstmid_quiet", {dn8, dn10, cnt8}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
